// File: rtl/multicycle_control_unit.sv
// Main FSM and ALU decoder for the multicycle RV32I core.
// The Moore controls are registered with the state. BRANCH pc_write and imm_src are combinational.
module multicycle_control_unit #(
    parameter int SUPPORT_BNE  = 1,
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic [2:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXECR  = 4'd6,  S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_HALT   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic [2:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, out_c;
    logic [2:0] alu_dec;
    logic       alu_ok, br_ok;

    function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] alu_sel);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_b  = 3'b010;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 3'b001;
                c.alu_src_b = 3'b001;
            end
            S_MEMADR: begin
                c.alu_src_a = 3'b010;
                c.alu_src_b = 3'b001;
            end
            S_MEMRD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a   = 3'b010;
                c.alu_control = alu_sel;
            end
            S_EXECI: begin
                c.alu_src_a   = 3'b010;
                c.alu_src_b   = 3'b001;
                c.alu_control = alu_sel;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a   = 3'b010;
                c.alu_control = ALU_SUB;
            end
            S_JAL: begin
                c.alu_src_a = 3'b001;
                c.alu_src_b = 3'b010;
                c.pc_write  = 1'b1;
            end
            S_HALT: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // funct7 only selects sub on R-type; I-type has op[5]=0 so addi never becomes sub.
    always_comb begin
        alu_dec = ALU_ADD;
        alu_ok  = 1'b1;
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_ok  = 1'b0;
        endcase
    end

    assign br_ok = (funct3 == 3'b000) || ((SUPPORT_BNE != 0) && (funct3 == 3'b001));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW)  state_d = S_MEMADR;
                else if (op == OP_R && alu_ok)   state_d = S_EXECR;
                else if (op == OP_I && alu_ok)   state_d = S_EXECI;
                else if (op == OP_BR && br_ok)   state_d = S_BRANCH;
                else if (op == OP_JAL)           state_d = S_JAL;
                else if (ILLEGAL_HALT != 0)      state_d = S_HALT;
                else                             state_d = S_FETCH;
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JAL:    state_d = S_ALUWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_of(S_FETCH, ALU_ADD);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d, alu_dec);
        end
    end

    // Reset overrides combinationally so an aborted instruction cannot write in the reset cycle.
    always_comb begin
        out_c = ctrl_q;
        if (reset) begin
            out_c          = ctrl_of(S_FETCH, ALU_ADD);
            out_c.pc_write = 1'b0;
            out_c.ir_write = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BR:   imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign pc_write    = out_c.pc_write
                       | (~reset & (state_q == S_BRANCH) & (zero ^ funct3[0]));
    assign adr_src     = out_c.adr_src;
    assign mem_write   = out_c.mem_write;
    assign ir_write    = out_c.ir_write;
    assign result_src  = out_c.result_src;
    assign alu_control = out_c.alu_control;
    assign alu_src_a   = out_c.alu_src_a;
    assign alu_src_b   = out_c.alu_src_b;
    assign reg_write   = out_c.reg_write;
    assign illegal     = out_c.illegal;
    assign state_dbg   = state_q;

endmodule
